// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - drives one combinational ALU per accepted command, waits a settle
// window, then captures the ALU output into a first-word-fall-through result FIFO.
module alu_op_sequencer #(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 1,
   parameter int FIFO_DEPTH    = 4,
   localparam int PTR_W        = $clog2(FIFO_DEPTH),
   localparam int LVL_W        = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [1:0]       cmd_s1,
   input  logic [2:0]       cmd_s2,
   input  logic [3:0]       cmd_s3,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_s1,
   output logic [2:0]       alu_s2,
   output logic [3:0]       alu_s3,
   input  logic [WIDTH-1:0] alu_o,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [LVL_W-1:0] fifo_level,
   output logic [15:0]      op_count
);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   state_t           state, next_state;
   logic [3:0]       settle_cnt;
   logic             accept, push, pop, push_ok;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem [FIFO_DEPTH];

   assign cmd_ready = (state == IDLE);
   assign res_valid = (fifo_level != '0);
   assign res_data  = mem[rd_ptr];
   assign pop       = res_valid && res_ready;
   // A pop on the same edge frees the slot, so a full FIFO can still take a push.
   assign push_ok   = (fifo_level < LVL_W'(FIFO_DEPTH)) || pop;

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      push       = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               accept     = 1'b1;
               next_state = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_cnt == 4'd0) begin
               if (push_ok) begin
                  push       = 1'b1;
                  next_state = IDLE;
               end else begin
                  next_state = HOLD;
               end
            end
         end
         HOLD: begin
            if (push_ok) begin
               push       = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         settle_cnt <= 4'd0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_s1     <= '0;
         alu_s2     <= '0;
         alu_s3     <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            alu_s1     <= cmd_s1;
            alu_s2     <= cmd_s2;
            alu_s3     <= cmd_s3;
            settle_cnt <= CNT_INIT;
         end else if (state == SETTLE && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         op_count   <= 16'd0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + PTR_W'(1);
            op_count <= op_count + 16'd1;
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LVL_W'(1);
            2'b01:   fifo_level <= fifo_level - LVL_W'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Storage needs no reset; the pointers and level define which entries are valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= alu_o;
   end

endmodule
